// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
// Contents: UART register addresses and the state enums of the main
// loader FSM and of the UART register-port sequencer.
package uart_boot_loader_pkg;

    localparam logic [1:0] RCV_BUF   = 2'd0;
    localparam logic [1:0] SND_BUF   = 2'd1;
    localparam logic [1:0] RCV_VALID = 2'd2;
    localparam logic [1:0] SND_READY = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLen,
        StNak,
        StWord,
        StMemW,
        StAck,
        StDone
    } main_state_e;

    typedef enum logic [3:0] {
        PortIdle,
        RxPoll,
        RxPw,
        RxRd,
        RxRw,
        TxPoll,
        TxPw,
        TxWr,
        TxGap1,
        TxGap2
    } port_state_e;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Bus bundle between the boot loader and its neighbours.
//   uart_*  : register port of the memory-mapped UART (rdata is registered by the UART)
//   mem_*   : instruction-memory write port (mem_we held until mem_ready)
// Modports: master = boot loader side, slave = UART/memory side.
interface uart_boot_loader_if;
    logic        uart_ce;
    logic [1:0]  uart_addr;
    logic        uart_read;
    logic        uart_write;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output uart_ce, uart_addr, uart_read, uart_write, uart_wdata,
        output mem_addr, mem_wdata, mem_we,
        input  uart_rdata, mem_ready
    );

    modport slave (
        input  uart_ce, uart_addr, uart_read, uart_write, uart_wdata,
        input  mem_addr, mem_wdata, mem_we,
        output uart_rdata, mem_ready
    );
endinterface

// File: rtl/uart_reg_port.sv
// UART register-port sequencer: byte fetch (get) and byte send (put) over the
// UART register bus, with all strobe timing handled here.
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   get_req, put_req : held by the main FSM until ack; get has priority
//   tx_byte          : byte to send, captured when a put is accepted
//   ack              : one-cycle completion; rx_byte is valid with ack of a get
//   uart_*           : UART register bus
module uart_reg_port
    import uart_boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        get_req,
    input  logic        put_req,
    input  logic [7:0]  tx_byte,
    output logic        ack,
    output logic [7:0]  rx_byte,
    output logic        uart_ce,
    output logic [1:0]  uart_addr,
    output logic        uart_read,
    output logic        uart_write,
    output logic [31:0] uart_wdata,
    input  logic [31:0] uart_rdata
);

    port_state_e state_q, state_d;
    logic [7:0]  tx_q;

    // Only the low byte and the status bit of rdata are meaningful.
    logic unused_rdata;
    assign unused_rdata = ^uart_rdata[31:8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= PortIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PortIdle: begin
                if (get_req) begin
                    state_d = RxPoll;
                end else if (put_req) begin
                    state_d = TxPoll;
                end
            end
            RxPoll:  state_d = RxPw;
            // rdata for the status read is valid in the wait cycle.
            RxPw:    state_d = uart_rdata[0] ? RxRd : RxPoll;
            RxRd:    state_d = RxRw;
            RxRw:    state_d = PortIdle;
            TxPoll:  state_d = TxPw;
            TxPw:    state_d = uart_rdata[0] ? TxWr : TxPoll;
            TxWr:    state_d = TxGap1;
            // snd-ready lags the write, so keep the bus quiet for two cycles.
            TxGap1:  state_d = TxGap2;
            TxGap2:  state_d = PortIdle;
            default: state_d = PortIdle;
        endcase
    end

    always_comb begin
        uart_read  = 1'b0;
        uart_write = 1'b0;
        uart_addr  = RCV_BUF;
        uart_wdata = 32'd0;
        ack        = 1'b0;
        unique case (state_q)
            RxPoll: begin
                uart_read = 1'b1;
                uart_addr = RCV_VALID;
            end
            RxRd: begin
                uart_read = 1'b1;
                uart_addr = RCV_BUF;
            end
            TxPoll: begin
                uart_read = 1'b1;
                uart_addr = SND_READY;
            end
            TxWr: begin
                uart_write = 1'b1;
                uart_addr  = SND_BUF;
                uart_wdata = {24'd0, tx_q};
            end
            RxRw, TxGap2: ack = 1'b1;
            default: ;
        endcase
        uart_ce = uart_read | uart_write;
    end

    assign rx_byte = uart_rdata[7:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_q <= 8'd0;
        end else if (state_q == PortIdle && !get_req && put_req) begin
            tx_q <= tx_byte;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: hunts for a sync byte, reads a little-endian word count,
// writes that many little-endian words to program memory, answers with an
// 8-bit checksum (or NAK for an oversized count) and releases the CPU.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : pulse; accepted only in IDLE or DONE
//   bus          : UART register bus and program-memory write port (master side)
//   cpu_hold     : holds the CPU in reset until a load completes
//   busy         : FSM outside IDLE/DONE
//   done, error  : sticky result flags of the last frame
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384,
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter logic [7:0]  NAK_BYTE  = 8'hEE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    uart_boot_loader_if.master  bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    main_state_e state_q, state_d;

    logic [1:0]  idx_q;
    logic [31:0] count_q;
    logic [31:0] word_cnt_q;
    logic [31:0] word_q;
    logic [31:0] addr_q;
    logic [7:0]  csum_q;
    logic        done_q;
    logic        error_q;
    logic        hold_q;

    logic        get_req;
    logic        put_req;
    logic [7:0]  tx_byte;
    logic        port_ack;
    logic [7:0]  rx_byte;
    logic        mem_we;

    logic        p_ce;
    logic [1:0]  p_addr;
    logic        p_read;
    logic        p_write;
    logic [31:0] p_wdata;

    // Count as it stands once the current byte is shifted in (complete on byte 3).
    logic [31:0] count_full;
    logic        len_last;
    logic        len_reject;
    assign count_full = {rx_byte, count_q[31:8]};
    assign len_last   = port_ack && (idx_q == 2'd3);
    assign len_reject = count_full > 32'(MAX_WORDS);

    uart_reg_port u_reg_port (
        .clock      (clock),
        .reset      (reset),
        .get_req    (get_req),
        .put_req    (put_req),
        .tx_byte    (tx_byte),
        .ack        (port_ack),
        .rx_byte    (rx_byte),
        .uart_ce    (p_ce),
        .uart_addr  (p_addr),
        .uart_read  (p_read),
        .uart_write (p_write),
        .uart_wdata (p_wdata),
        .uart_rdata (bus.uart_rdata)
    );

    assign bus.uart_ce    = p_ce;
    assign bus.uart_addr  = p_addr;
    assign bus.uart_read  = p_read;
    assign bus.uart_write = p_write;
    assign bus.uart_wdata = p_wdata;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = word_q;
    assign bus.mem_we     = mem_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StSync;
            StSync: if (port_ack && rx_byte == SYNC_BYTE) state_d = StLen;
            StLen: begin
                if (len_last) begin
                    if (count_full == 32'd0) begin
                        state_d = StAck;
                    end else if (len_reject) begin
                        state_d = StNak;
                    end else begin
                        state_d = StWord;
                    end
                end
            end
            StNak:  if (port_ack) state_d = StSync;
            StWord: if (port_ack && idx_q == 2'd3) state_d = StMemW;
            StMemW: begin
                if (bus.mem_ready) begin
                    state_d = (word_cnt_q + 32'd1 == count_q) ? StAck : StWord;
                end
            end
            StAck:  if (port_ack) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        get_req = 1'b0;
        put_req = 1'b0;
        tx_byte = csum_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StSync, StLen, StWord: get_req = 1'b1;
            StNak: begin
                put_req = 1'b1;
                tx_byte = NAK_BYTE;
            end
            StAck:  put_req = 1'b1;
            StMemW: mem_we  = 1'b1;
            default: ;
        endcase
        busy = (state_q != StIdle) && (state_q != StDone);
    end

    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q      <= 2'd0;
            count_q    <= 32'd0;
            word_cnt_q <= 32'd0;
            word_q     <= 32'd0;
            addr_q     <= BASE_ADDR;
            csum_q     <= 8'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end
                StSync: begin
                    // A fresh frame starts: restart the image at BASE_ADDR.
                    if (port_ack && rx_byte == SYNC_BYTE) begin
                        idx_q      <= 2'd0;
                        csum_q     <= 8'd0;
                        word_cnt_q <= 32'd0;
                        addr_q     <= BASE_ADDR;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                StLen: begin
                    if (port_ack) begin
                        count_q <= count_full;
                        csum_q  <= csum_q + rx_byte;
                        idx_q   <= idx_q + 2'd1;
                        if (len_last && len_reject) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StWord: begin
                    if (port_ack) begin
                        word_q <= {rx_byte, word_q[31:8]};
                        csum_q <= csum_q + rx_byte;
                        idx_q  <= idx_q + 2'd1;
                    end
                end
                StMemW: begin
                    if (bus.mem_ready) begin
                        addr_q     <= addr_q + 32'd4;
                        word_cnt_q <= word_cnt_q + 32'd1;
                    end
                end
                StAck: begin
                    if (port_ack) begin
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: behavioural UART with registered
// rdata, memory model with programmable mem_ready delay, scoreboard queues for
// expected UART transmissions and memory writes.
module tb_uart_boot_loader;
    import uart_boot_loader_pkg::*;

    localparam logic [7:0] SYNC = 8'h55;
    localparam logic [7:0] NAK  = 8'hEE;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    uart_boot_loader_if bus ();

    uart_boot_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard and model state
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] wbuf[4];

    logic        snd_ready_m = 1'b1;
    int          mem_delay   = 0;
    int          mem_wait    = 0;
    logic        ready_m     = 1'b0;
    logic [31:0] nxt_rdata   = 32'd0;
    int          tx_seen     = 0;
    int          wr_seen     = 0;
    logic        prev_strobe = 1'b0;
    logic        strobe;
    int          gap         = 3;
    logic        in_wait     = 1'b0;
    logic [31:0] hold_addr, hold_data;

    assign bus.mem_ready = ready_m;

    // UART register: rdata updates on the edge ending the strobe cycle.
    always @(posedge clock) bus.uart_rdata <= nxt_rdata;

    always @(negedge clock) begin
        if (reset) begin
            prev_strobe = 1'b0;
            gap         = 3;
            in_wait     = 1'b0;
            ready_m     = 1'b0;
            mem_wait    = 0;
        end else begin
            strobe = bus.uart_read | bus.uart_write;
            if (strobe || bus.uart_ce) begin
                check_eq("ce_match", {31'd0, bus.uart_ce}, {31'd0, strobe});
                check_eq("rd_wr_excl", {31'd0, bus.uart_read & bus.uart_write}, 32'd0);
                check_eq("back_to_back", {31'd0, prev_strobe}, 32'd0);
                check_eq("tx_gap", {31'd0, gap >= 2}, 32'd1);
            end
            if (bus.uart_read) begin
                case (bus.uart_addr)
                    2'd0: nxt_rdata = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
                    2'd2: nxt_rdata = {31'd0, rx_q.size() > 0};
                    2'd3: nxt_rdata = {31'd0, snd_ready_m};
                    default: nxt_rdata = 32'd0;
                endcase
            end
            if (bus.uart_write) begin
                tx_seen++;
                check_eq("tx_addr", {30'd0, bus.uart_addr}, 32'd1);
                if (exp_tx.size() > 0) begin
                    check_eq("tx_byte", bus.uart_wdata, {24'd0, exp_tx.pop_front()});
                end else begin
                    check_eq("tx_queue", exp_tx.size(), 32'd1);
                end
            end
            if (bus.uart_write) gap = 0;
            else if (gap < 3) gap++;
            prev_strobe = strobe;

            // Memory: ready decided here for the coming edge.
            if (bus.mem_we) begin
                if (!in_wait) begin
                    hold_addr = bus.mem_addr;
                    hold_data = bus.mem_wdata;
                    in_wait   = 1'b1;
                end else begin
                    check_eq("maddr_stable", bus.mem_addr, hold_addr);
                    check_eq("mdata_stable", bus.mem_wdata, hold_data);
                end
                if (mem_wait >= mem_delay) begin
                    ready_m  = 1'b1;
                    mem_wait = 0;
                    wr_seen++;
                    if (exp_addr.size() > 0) begin
                        check_eq("mem_addr", bus.mem_addr, exp_addr.pop_front());
                        check_eq("mem_data", bus.mem_wdata, exp_data.pop_front());
                    end else begin
                        check_eq("mem_queue", exp_addr.size(), 32'd1);
                    end
                end else begin
                    ready_m = 1'b0;
                    mem_wait++;
                end
            end else begin
                ready_m  = 1'b0;
                mem_wait = 0;
                in_wait  = 1'b0;
            end
        end
    end

    // Queue a frame built from wbuf; expected results go to the scoreboard.
    task automatic push_frame(input logic [31:0] count);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        rx_q.push_back(SYNC);
        for (int i = 0; i < 4; i++) begin
            b = count[8*i +: 8];
            rx_q.push_back(b);
            sum += b;
        end
        if (count > 32'd16384) begin
            exp_tx.push_back(NAK);
            return;
        end
        for (int w = 0; w < int'(count); w++) begin
            for (int i = 0; i < 4; i++) begin
                b = wbuf[w][8*i +: 8];
                rx_q.push_back(b);
                sum += b;
            end
            exp_addr.push_back(32'(4 * w));
            exp_data.push_back(wbuf[w]);
        end
        exp_tx.push_back(sum);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_flag(input bit want_error, input int budget);
        int n = 0;
        while (!(want_error ? error : done) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq(want_error ? "wait_error" : "wait_done",
                 {31'd0, want_error ? error : done}, 32'd1);
    endtask

    task automatic wait_rx_empty(input int budget);
        int n = 0;
        while (rx_q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("rx_drained", rx_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ce"},    {31'd0, bus.uart_ce}, 32'd0);
        check_eq({tag, "_rd"},    {31'd0, bus.uart_read}, 32'd0);
        check_eq({tag, "_wr"},    {31'd0, bus.uart_write}, 32'd0);
        check_eq({tag, "_uaddr"}, {30'd0, bus.uart_addr}, 32'd0);
        check_eq({tag, "_wdata"}, bus.uart_wdata, 32'd0);
        check_eq({tag, "_maddr"}, bus.mem_addr, 32'd0);
        check_eq({tag, "_mdata"}, bus.mem_wdata, 32'd0);
        check_eq({tag, "_mwe"},   {31'd0, bus.mem_we}, 32'd0);
        check_eq({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
        check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_tx_left"},  exp_tx.size(), 32'd0);
        check_eq({tag, "_mem_left"}, exp_addr.size(), 32'd0);
    endtask

    initial begin
        int wr0, tx0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("post_rst");

        // 1) Basic two-word load
        wr0 = wr_seen;
        wbuf[0] = 32'h1234_5678;
        wbuf[1] = 32'hDEAD_BEEF;
        push_frame(32'd2);
        pulse_start();
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        wait_flag(1'b0, 2000);
        check_eq("t1_hold", {31'd0, cpu_hold}, 32'd0);
        check_eq("t1_error", {31'd0, error}, 32'd0);
        check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t1_writes", wr_seen - wr0, 32'd2);
        check_drained("t1");

        // 2) Noise before sync, zero count
        wr0 = wr_seen;
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'h13);
        push_frame(32'd0);
        pulse_start();
        check_eq("t2_hold_start", {31'd0, cpu_hold}, 32'd1);
        check_eq("t2_done_clr", {31'd0, done}, 32'd0);
        wait_flag(1'b0, 2000);
        check_eq("t2_writes", wr_seen - wr0, 32'd0);
        check_eq("t2_hold", {31'd0, cpu_hold}, 32'd0);
        check_drained("t2");

        // 3) Oversized count is rejected, then a valid frame loads
        push_frame(32'h0000_4001);
        pulse_start();
        wait_flag(1'b1, 2000);
        check_eq("t3_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("t3_done", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clock);
        check_eq("t3_error_sticky", {31'd0, error}, 32'd1);
        check_drained("t3_nak");
        wbuf[0] = 32'hCAFE_F00D;
        push_frame(32'd1);
        wait_flag(1'b0, 2000);
        check_eq("t3_error_clr", {31'd0, error}, 32'd0);
        check_eq("t3_hold_rel", {31'd0, cpu_hold}, 32'd0);
        check_drained("t3");

        // 4) Slow memory; a start while busy is ignored
        mem_delay = 3;
        wr0 = wr_seen;
        wbuf[0] = 32'h0102_0304;
        wbuf[1] = 32'hA0B0_C0D0;
        wbuf[2] = 32'hFFFF_0001;
        push_frame(32'd3);
        pulse_start();
        repeat (20) @(negedge clock);
        check_eq("t4_busy", {31'd0, busy}, 32'd1);
        pulse_start();
        wait_flag(1'b0, 3000);
        check_eq("t4_writes", wr_seen - wr0, 32'd3);
        check_drained("t4");
        mem_delay = 0;

        // 5) Send-ready withheld at ACK
        snd_ready_m = 1'b0;
        wbuf[0] = 32'h7777_8888;
        push_frame(32'd1);
        pulse_start();
        tx0 = tx_seen;
        wait_rx_empty(2000);
        repeat (50) @(negedge clock);
        check_eq("t5_no_tx", tx_seen - tx0, 32'd0);
        check_eq("t5_busy", {31'd0, busy}, 32'd1);
        check_eq("t5_done", {31'd0, done}, 32'd0);
        snd_ready_m = 1'b1;
        wait_flag(1'b0, 2000);
        check_eq("t5_tx", tx_seen - tx0, 32'd1);
        check_drained("t5");

        // 6) Reset in the middle of a word
        rx_q.push_back(SYNC);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        pulse_start();
        wait_rx_empty(2000);
        repeat (10) @(negedge clock);
        check_eq("t6_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clock);
        reset = 1'b0;
        rx_q.delete();
        exp_tx.delete();
        wbuf[0] = 32'hA5A5_5A5A;
        wbuf[1] = 32'h0F0F_F0F0;
        push_frame(32'd2);
        pulse_start();
        wait_flag(1'b0, 2000);
        check_eq("t6_hold", {31'd0, cpu_hold}, 32'd0);
        check_drained("t6");

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
